// File: rtl/bias_relu_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : bias_relu_wb_if
// Description : Bundles every bus of the bias/ReLU writeback stage:
//               - CPU register port (Avalon-MM slave)
//               - sum stream from the dot-product engine (valid/ready)
//               - SDRAM bias-read master and SRAM activation-write master
//               - done level output
//               Modport "slave" is the stage's own view of these buses.
//               Modport "master" is the view of the surrounding system
//               (CPU, dot engine and memories) that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface bias_relu_wb_if;
    // CPU register port
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    // Sum stream from the dot-product engine
    logic        sum_valid;
    logic        sum_ready;
    logic [31:0] sum_data;
    // SDRAM bias reads
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    // SRAM activation writes
    logic        master2_waitrequest;
    logic [31:0] master2_address;
    logic        master2_write;
    logic [31:0] master2_writedata;
    // Completion
    logic        done;

    modport slave (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata,
        input  sum_valid, sum_data,
        output sum_ready,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output master_address, master_read,
        input  master2_waitrequest,
        output master2_address, master2_write, master2_writedata,
        output done
    );

    modport master (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata,
        output sum_valid, sum_data,
        input  sum_ready,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  master_address, master_read,
        output master2_waitrequest,
        input  master2_address, master2_write, master2_writedata,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/bias_relu_wb.sv
`default_nettype none
// ============================================================================
// Module      : bias_relu_wb
// Description : Adds a Q16.16 bias (read from SDRAM) to every neuron sum
//               produced by the dot-product engine, saturates to 32 bits,
//               optionally applies ReLU, and writes the activation to SRAM.
//               Sums are buffered in a FIFO_DEPTH-entry FIFO so the dot
//               engine can run ahead of the writeback.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - bias_relu_wb_if.slave: CPU registers, sum stream,
//                      SDRAM bias-read master, SRAM write master, done
// Registers   : 0 W start / R {busy, done}, 1 bias_base, 2 out_base,
//               3 neuron_count, 4 relu_en (bit 0), 5 R processed count
// Revision    : 1.0 - initial release
// ============================================================================
module bias_relu_wb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    bias_relu_wb_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_POP  = 3'd1;
    localparam logic [2:0] c_RDB  = 3'd2;
    localparam logic [2:0] c_WTB  = 3'd3;
    localparam logic [2:0] c_WR   = 3'd4;
    localparam logic [2:0] c_FIN  = 3'd5;

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;

    logic [31:0]  r_bias_base;
    logic [31:0]  r_out_base;
    logic [31:0]  r_neuron_count;
    logic         r_relu_en;
    logic         r_done;
    logic [31:0]  r_processed;
    logic [31:0]  r_accepted;
    logic [31:0]  r_acc;
    logic [31:0]  r_result;

    logic [31:0]  r_fifo [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;

    logic         w_busy;
    logic         w_empty;
    logic         w_full;
    logic         w_sum_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_start;
    logic         w_cfg_wr;
    logic         w_last;
    logic [31:0]  w_n_offset;
    logic [32:0]  w_sum33;
    logic [31:0]  w_sat;
    logic [31:0]  w_act;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_busy      = (r_state == c_POP) || (r_state == c_RDB) ||
                         (r_state == c_WTB) || (r_state == c_WR);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                         (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    // Never accept more sums than neurons in this run.
    assign w_sum_ready = w_busy && !w_full && (r_accepted < r_neuron_count);
    assign w_push      = bus.sum_valid && w_sum_ready;
    assign w_pop       = (r_state == c_POP) && !w_empty;
    assign w_start     = bus.slave_write && (bus.slave_address == 4'd0) &&
                         (r_state == c_IDLE);
    assign w_cfg_wr    = bus.slave_write && !w_busy;
    assign w_last      = ((r_processed + 32'd1) == r_neuron_count);
    assign w_n_offset  = {r_processed[29:0], 2'b00};

    // ------------------------------------------------------------------
    // Bias add with signed saturation, then optional ReLU
    // ------------------------------------------------------------------
    assign w_sum33 = {r_acc[31], r_acc} +
                     {bus.master_readdata[31], bus.master_readdata};
    // Overflow when the sign-extension bit disagrees with bit 31.
    assign w_sat   = (w_sum33[32] != w_sum33[31]) ?
                     (w_sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) :
                     w_sum33[31:0];
    assign w_act   = (r_relu_en && w_sat[31]) ? 32'd0 : w_sat;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_start) w_next_state = (r_neuron_count == 32'd0) ? c_FIN : c_POP;
            c_POP:  if (!w_empty) w_next_state = c_RDB;
            c_RDB:  if (!bus.master_waitrequest) w_next_state = c_WTB;
            c_WTB:  if (bus.master_readdatavalid) w_next_state = c_WR;
            c_WR:   if (!bus.master2_waitrequest) w_next_state = w_last ? c_FIN : c_POP;
            c_FIN:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (requests derive from state so reset drops them at once)
    // ------------------------------------------------------------------
    always_comb begin
        bus.master_read       = 1'b0;
        bus.master_address    = 32'd0;
        bus.master2_write     = 1'b0;
        bus.master2_address   = 32'd0;
        bus.master2_writedata = 32'd0;
        bus.sum_ready         = w_sum_ready;
        bus.done              = r_done;
        case (r_state)
            c_RDB: begin
                bus.master_read    = 1'b1;
                bus.master_address = r_bias_base + w_n_offset;
            end
            c_WR: begin
                bus.master2_write     = 1'b1;
                bus.master2_address   = r_out_base + w_n_offset;
                bus.master2_writedata = r_result;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read port
    // ------------------------------------------------------------------
    always_comb begin
        bus.slave_readdata = 32'd0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0:    bus.slave_readdata = {30'd0, w_busy, r_done};
                4'd5:    bus.slave_readdata = r_processed;
                default: bus.slave_readdata = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Configuration, counters and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias_base    <= 32'd0;
            r_out_base     <= 32'd0;
            r_neuron_count <= 32'd0;
            r_relu_en      <= 1'b0;
            r_done         <= 1'b0;
            r_processed    <= 32'd0;
            r_accepted     <= 32'd0;
            r_acc          <= 32'd0;
            r_result       <= 32'd0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
        end else begin
            if (w_cfg_wr) begin
                case (bus.slave_address)
                    4'd1:    r_bias_base    <= bus.slave_writedata;
                    4'd2:    r_out_base     <= bus.slave_writedata;
                    4'd3:    r_neuron_count <= bus.slave_writedata;
                    4'd4:    r_relu_en      <= bus.slave_writedata[0];
                    default: ;
                endcase
            end

            if (w_start) begin
                r_processed <= 32'd0;
                r_accepted  <= 32'd0;
            end else if (w_push) begin
                r_accepted  <= r_accepted + 32'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_acc    <= r_fifo[r_rd_ptr[c_PTR_W-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if ((r_state == c_WTB) && bus.master_readdatavalid) begin
                r_result <= w_act;
            end

            if ((r_state == c_WR) && !bus.master2_waitrequest) begin
                r_processed <= r_processed + 32'd1;
            end

            // A zero-count start goes straight to FIN, so setting wins.
            if (w_next_state == c_FIN) begin
                r_done <= 1'b1;
            end else if (w_start) begin
                r_done <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= bus.sum_data;
        end
    end

endmodule
`default_nettype wire
